blake2_block_ctrl: RTL and testbench

- Sequencing controller between the byte-serial host I/O front end and the BLAKE2s compression datapath.
- Consumes the decoded config (kk, nn, ll) and the per-byte block stream.
- Steers block-buffer writes, zero-pads the final partial block, and issues compression requests with the correct byte counter t and final flag.
- After the final compression, serialises nn digest bytes back to the host.

---
 rtl/blake2_pkg.sv | 40 ++++
 rtl/blake2_digest_ser.sv | 68 ++++++
 rtl/blake2_block_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_blake2_block_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_pkg
//  Description : Shared types and constants for the BLAKE2s block sequencing
//                controller and the byte-serial host I/O front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package blake2_pkg;

    // Block size, maximum digest length and maximum key length in bytes
    localparam int BB     = 64;
    localparam int NN_MAX = 32;
    localparam int KK_MAX = 32;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_FILL = 3'd2,
        ST_PAD  = 3'd3,
        ST_COMP = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    // Host command encodings decoded by the I/O front end
    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_CFG  = 2'd1;
    localparam logic [1:0] CMD_DATA = 2'd2;
    localparam logic [1:0] CMD_HASH = 2'd3;

    // A configuration the datapath cannot honour: empty or oversize digest,
    // or a key longer than the BLAKE2s limit
    function automatic logic cfg_bad(input logic [7:0] kk,
                                     input logic [7:0] nn,
                                     input logic [7:0] nn_max);
        return (nn == 8'd0) || (nn > nn_max) || (kk > 8'(KK_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/blake2_digest_ser.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_digest_ser
//  Description : Serialises nn digest bytes out of the hash state h. Started
//                by a one-cycle pulse; reports completion with the finished
//                pulse that accompanies the last byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module blake2_digest_ser #(
    parameter int NN_MAX = 32
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start_i,
    input  logic [7:0] nn_i,
    output logic [4:0] rd_idx_o,
    input  logic [7:0] hash_byte_i,
    output logic       hash_v_o,
    output logic [7:0] hash_o,
    output logic       finished_o,
    output logic       done_o
);

    logic       r_active;
    logic [5:0] r_cnt;
    logic       r_fin;
    logic       w_last;

    // The last byte is the nn-th one; clamped at NN_MAX so a bad nn can
    // never make the read address run past the state
    assign w_last = (({2'b00, r_cnt} + 8'd1) >= nn_i) ||
                    (r_cnt == 6'(NN_MAX - 1));

    assign rd_idx_o   = r_cnt[4:0];
    assign finished_o = r_fin;
    assign done_o     = r_fin;

    // Address counter walks h; the read byte is registered one cycle later
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_active <= 1'b0;
            r_cnt    <= 6'd0;
            r_fin    <= 1'b0;
            hash_v_o <= 1'b0;
            hash_o   <= 8'h00;
        end else begin
            hash_v_o <= 1'b0;
            hash_o   <= 8'h00;
            r_fin    <= 1'b0;
            if (start_i) begin
                r_active <= 1'b1;
                r_cnt    <= 6'd0;
            end else if (r_active) begin
                hash_v_o <= 1'b1;
                hash_o   <= hash_byte_i;
                if (w_last) begin
                    r_active <= 1'b0;
                    r_fin    <= 1'b1;
                    r_cnt    <= 6'd0;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/blake2_block_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_block_ctrl
//  Description : Sequencing controller between the byte-serial host front end
//                and the BLAKE2s compression datapath. Steers block-buffer
//                writes, zero-pads the final block, issues compressions with
//                the byte counter t and final flag, then streams the digest.
//                Optional protocol checking: define BLAKE2_CTRL_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module blake2_block_ctrl #(
    parameter int BB     = 64,
    parameter int NN_MAX = 32,
    parameter int T_W    = 64
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [7:0]     kk_i,
    input  logic [7:0]     nn_i,
    input  logic [63:0]    ll_i,
    input  logic           data_v_i,
    input  logic [5:0]     data_idx_i,
    input  logic           block_first_i,
    input  logic           block_last_i,
    output logic           busy_o,
    output logic           buf_we_o,
    output logic [5:0]     buf_idx_o,
    output logic           buf_zero_o,
    output logic           h_init_o,
    output logic           cmp_start_o,
    output logic [T_W-1:0] cmp_t_o,
    output logic           cmp_last_o,
    input  logic           cmp_done_i,
    output logic [4:0]     hash_rd_idx_o,
    input  logic [7:0]     hash_byte_i,
    output logic           hash_v_o,
    output logic [7:0]     hash_o,
    output logic           hash_finished_o,
    output logic           err_o
);

    import blake2_pkg::*;

    localparam logic [5:0]     c_LAST_IDX  = 6'(BB - 1);
    localparam logic [T_W-1:0] c_KEY_BLOCK = T_W'(BB);
    localparam logic [T_W-1:0] c_ONE       = T_W'(1);

    state_t         r_state;
    logic [T_W-1:0] r_t;          // bytes accepted so far (key block included)
    logic [T_W-1:0] r_target;     // total bytes the host will send
    logic [7:0]     r_nn;
    logic [5:0]     r_pad_idx;
    logic [5:0]     r_exp_idx;    // next block index the host should send
    logic           r_ser_start;

    logic [T_W-1:0] w_target_in;
    logic           w_empty_in;
    logic           w_start;
    logic           w_accept_idle;
    logic           w_accept_fill;
    logic [T_W-1:0] w_t_inc;
    logic           w_blk_end;
    logic           w_reach;
    logic           w_ser_done;

    // A keyed message is preceded by one full zero-padded key block
    assign w_target_in = T_W'(ll_i) + ((kk_i != 8'd0) ? c_KEY_BLOCK : '0);
    assign w_empty_in  = (w_target_in == '0);

    // An empty unkeyed message carries no byte, so the front end marks it
    // with first and last both high and no valid byte
    assign w_start       = block_first_i & (data_v_i | (block_last_i & w_empty_in));
    assign w_accept_idle = (r_state == ST_IDLE) & w_start & data_v_i & ~w_empty_in;
    assign w_accept_fill = (r_state == ST_FILL) & data_v_i;

    assign w_t_inc   = r_t + c_ONE;
    assign w_blk_end = (data_idx_i == c_LAST_IDX);
    assign w_reach   = (w_t_inc >= r_target);

    // Buffer write port: host bytes pass straight through, padding is zeros
    always_comb begin
        buf_we_o   = 1'b0;
        buf_idx_o  = 6'd0;
        buf_zero_o = 1'b0;
        if (w_accept_idle || w_accept_fill) begin
            buf_we_o  = 1'b1;
            buf_idx_o = data_idx_i;
        end else if (r_state == ST_PAD) begin
            buf_we_o   = 1'b1;
            buf_idx_o  = r_pad_idx;
            buf_zero_o = 1'b1;
        end
    end

    // Main sequencer with registered pulses, counter and busy flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_t         <= '0;
            r_target    <= '0;
            r_nn        <= 8'd0;
            r_pad_idx   <= 6'd0;
            r_exp_idx   <= 6'd0;
            r_ser_start <= 1'b0;
            busy_o      <= 1'b0;
            h_init_o    <= 1'b0;
            cmp_start_o <= 1'b0;
            cmp_t_o     <= '0;
            cmp_last_o  <= 1'b0;
        end else begin
            h_init_o    <= 1'b0;
            cmp_start_o <= 1'b0;
            r_ser_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_INIT;
                        busy_o    <= 1'b1;
                        h_init_o  <= 1'b1;
                        r_target  <= w_target_in;
                        r_nn      <= nn_i;
                        r_t       <= w_accept_idle ? c_ONE : '0;
                        r_exp_idx <= w_accept_idle ? (data_idx_i + 6'd1) : 6'd0;
                    end
                end
                ST_INIT: begin
                    // Empty message, or a one-byte message already complete
                    if (r_t >= r_target) begin
                        r_state   <= ST_PAD;
                        r_pad_idx <= r_exp_idx;
                    end else begin
                        r_state <= ST_FILL;
                        busy_o  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (data_v_i) begin
                        r_t       <= w_t_inc;
                        r_exp_idx <= data_idx_i + 6'd1;
                        if (w_blk_end) begin
                            r_state     <= ST_COMP;
                            busy_o      <= 1'b1;
                            cmp_start_o <= 1'b1;
                            cmp_t_o     <= w_t_inc;
                            cmp_last_o  <= w_reach;
                        end else if (w_reach) begin
                            r_state   <= ST_PAD;
                            busy_o    <= 1'b1;
                            r_pad_idx <= data_idx_i + 6'd1;
                        end
                    end
                end
                ST_PAD: begin
                    // Padding bytes are not counted in t
                    if (r_pad_idx == c_LAST_IDX) begin
                        r_state     <= ST_COMP;
                        cmp_start_o <= 1'b1;
                        cmp_t_o     <= r_t;
                        cmp_last_o  <= 1'b1;
                    end else begin
                        r_pad_idx <= r_pad_idx + 6'd1;
                    end
                end
                ST_COMP: begin
                    // Checked from the entry cycle so a same-cycle done counts
                    if (cmp_done_i) begin
                        if (cmp_last_o) begin
                            r_state     <= ST_OUT;
                            r_ser_start <= 1'b1;
                        end else begin
                            r_state <= ST_FILL;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                ST_OUT: begin
                    if (w_ser_done) begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    blake2_digest_ser #(
        .NN_MAX (NN_MAX)
    ) u_digest_ser (
        .clk         (clk),
        .nreset      (nreset),
        .start_i     (r_ser_start),
        .nn_i        (r_nn),
        .rd_idx_o    (hash_rd_idx_o),
        .hash_byte_i (hash_byte_i),
        .hash_v_o    (hash_v_o),
        .hash_o      (hash_o),
        .finished_o  (hash_finished_o),
        .done_o      (w_ser_done)
    );

`ifdef BLAKE2_CTRL_ERR_EN
    logic r_err;

    // Sticky protocol error; a new message restarts it from its own config
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_err <= cfg_bad(kk_i, nn_i, 8'(NN_MAX));
                    end
                end
                ST_FILL: begin
                    if (data_v_i && (data_idx_i != r_exp_idx)) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    if (data_v_i) begin
                        r_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blake2_block_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blake2_block_ctrl
//  Description : Directed self-checking bench for blake2_block_ctrl with a
//                byte-serial host model and a compression datapath responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blake2_block_ctrl;

`ifdef BLAKE2_CTRL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic [7:0]  kk_i, nn_i;
    logic [63:0] ll_i;
    logic        data_v_i;
    logic [5:0]  data_idx_i;
    logic        block_first_i, block_last_i;
    logic        busy_o, buf_we_o, buf_zero_o, h_init_o, cmp_start_o, cmp_last_o;
    logic [5:0]  buf_idx_o;
    logic [63:0] cmp_t_o;
    logic        cmp_done_i;
    logic [4:0]  hash_rd_idx_o;
    logic [7:0]  hash_byte_i;
    logic        hash_v_o, hash_finished_o, err_o;
    logic [7:0]  hash_o;

    int tests = 0;
    int fails = 0;

    // Observations gathered by run_msg
    int n_init, n_data, n_pad, pad_first, pad_err, idx_err;
    int n_hash, hash_err, n_fin, fin_ok, n_cmp;
    bit inj_we;
    logic [63:0] cmp_t_q[$];
    logic        cmp_last_q[$];

    always #5 clk = ~clk;

    // Hash state stand-in: byte k of h is k ^ 0xA5
    assign hash_byte_i = {3'b000, hash_rd_idx_o} ^ 8'hA5;

    blake2_block_ctrl dut (
        .clk(clk), .nreset(nreset), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
        .data_v_i(data_v_i), .data_idx_i(data_idx_i),
        .block_first_i(block_first_i), .block_last_i(block_last_i),
        .busy_o(busy_o), .buf_we_o(buf_we_o), .buf_idx_o(buf_idx_o),
        .buf_zero_o(buf_zero_o), .h_init_o(h_init_o), .cmp_start_o(cmp_start_o),
        .cmp_t_o(cmp_t_o), .cmp_last_o(cmp_last_o), .cmp_done_i(cmp_done_i),
        .hash_rd_idx_o(hash_rd_idx_o), .hash_byte_i(hash_byte_i),
        .hash_v_o(hash_v_o), .hash_o(hash_o), .hash_finished_o(hash_finished_o),
        .err_o(err_o)
    );

    // Host + datapath model for one message; stops on the finished pulse,
    // or on the first digest byte when abort_out is set
    task automatic run_msg(input logic [7:0] kk, input logic [7:0] nn,
                           input logic [63:0] ll, input int delay,
                           input bit inject, input bit abort_out);
        logic [63:0] target, sent, last_start;
        int cyc, done_cnt;
        bit stop, started, sending, injected, inj_now;
        n_init = 0; n_data = 0; n_pad = 0; pad_first = -1; pad_err = 0; idx_err = 0;
        n_hash = 0; hash_err = 0; n_fin = 0; fin_ok = 0; n_cmp = 0; inj_we = 0;
        cmp_t_q.delete(); cmp_last_q.delete();
        kk_i = kk; nn_i = nn; ll_i = ll;
        target = ll + ((kk != 8'd0) ? 64'd64 : 64'd0);
        last_start = (target == 64'd0) ? 64'd0 : (((target - 64'd1) >> 6) << 6);
        sent = 0; cyc = 0; done_cnt = 0; stop = 0; started = 0; injected = 0;
        while (!stop && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
            if (h_init_o) n_init++;
            if (hash_v_o) begin
                if (hash_o !== (n_hash[7:0] ^ 8'hA5)) hash_err++;
                n_hash++;
            end
            if (hash_finished_o) begin
                n_fin++;
                if (hash_v_o && n_hash == int'(nn)) fin_ok++;
                stop = 1;
            end
            if (abort_out && hash_v_o) stop = 1;
            cmp_done_i = 0; data_v_i = 0; data_idx_i = 0;
            block_first_i = 0; block_last_i = 0; sending = 0; inj_now = 0;
            if (!stop) begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) cmp_done_i = 1;
                end
                if (cmp_start_o) begin
                    n_cmp++;
                    cmp_t_q.push_back(cmp_t_o);
                    cmp_last_q.push_back(cmp_last_o);
                    if (delay == 0) cmp_done_i = 1; else done_cnt = delay;
                end
                if (inject && cmp_start_o && !injected) begin
                    data_v_i = 1; data_idx_i = 6'd5; injected = 1; inj_now = 1;
                end else if (!busy_o && sent < target) begin
                    data_v_i = 1; data_idx_i = sent[5:0];
                    block_first_i = (sent < 64'd64);
                    block_last_i = (sent >= last_start);
                    sending = 1;
                end else if (!busy_o && target == 64'd0 && !started) begin
                    block_first_i = 1; block_last_i = 1; started = 1;
                end
                #1;
                if (buf_we_o) begin
                    if (buf_zero_o) begin
                        if (n_pad == 0) pad_first = int'(buf_idx_o);
                        else if (int'(buf_idx_o) != pad_first + n_pad) pad_err++;
                        n_pad++;
                    end else begin
                        if (!sending || buf_idx_o !== sent[5:0]) idx_err++;
                        n_data++;
                    end
                    if (inj_now) inj_we = 1;
                end
                if (sending) sent++;
            end
        end
        data_v_i = 0; cmp_done_i = 0; block_first_i = 0; block_last_i = 0;
    endtask

    task automatic test_reset();
        logic [95:0] outs;
        nreset = 0; kk_i = 0; nn_i = 0; ll_i = 0; data_v_i = 0; data_idx_i = 0;
        block_first_i = 0; block_last_i = 0; cmp_done_i = 0;
        repeat (3) @(posedge clk);
        #1;
        outs = {busy_o, buf_we_o, buf_idx_o, buf_zero_o, h_init_o, cmp_start_o, cmp_t_o,
                cmp_last_o, hash_rd_idx_o, hash_v_o, hash_o, hash_finished_o, err_o};
        tests++; if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
        nreset = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_empty();
        run_msg(8'd0, 8'd32, 64'd0, 3, 0, 0);
        tests++; if (n_init != 1) begin fails++; $display("FAIL empty_h_init: got %0d want 1", n_init); end
        tests++; if (n_data != 0) begin fails++; $display("FAIL empty_data: got %0d want 0", n_data); end
        tests++; if (n_pad != 64 || pad_first != 0 || pad_err != 0) begin fails++; $display("FAIL empty_pad: got n=%0d first=%0d err=%0d want 64/0/0", n_pad, pad_first, pad_err); end
        tests++; if (n_cmp != 1 || cmp_t_q[0] !== 64'd0 || cmp_last_q[0] !== 1'b1) begin fails++; $display("FAIL empty_cmp: got n=%0d t=%0d last=%b want 1/0/1", n_cmp, cmp_t_q[0], cmp_last_q[0]); end
        tests++; if (n_hash != 32 || hash_err != 0) begin fails++; $display("FAIL empty_hash: got n=%0d bad=%0d want 32/0", n_hash, hash_err); end
        tests++; if (n_fin != 1 || fin_ok != 1) begin fails++; $display("FAIL empty_finished: got n=%0d on_last=%0d want 1/1", n_fin, fin_ok); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL empty_back_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_short();
        run_msg(8'd0, 8'd32, 64'd3, 2, 0, 0);
        tests++; if (n_data != 3 || idx_err != 0) begin fails++; $display("FAIL ll3_data: got n=%0d bad=%0d want 3/0", n_data, idx_err); end
        tests++; if (n_pad != 61 || pad_first != 3 || pad_err != 0) begin fails++; $display("FAIL ll3_pad: got n=%0d first=%0d err=%0d want 61/3/0", n_pad, pad_first, pad_err); end
        tests++; if (n_cmp != 1 || cmp_t_q[0] !== 64'd3 || cmp_last_q[0] !== 1'b1) begin fails++; $display("FAIL ll3_cmp: got n=%0d t=%0d last=%b want 1/3/1", n_cmp, cmp_t_q[0], cmp_last_q[0]); end
        tests++; if (n_hash != 32 || n_fin != 1) begin fails++; $display("FAIL ll3_out: got bytes=%0d fin=%0d want 32/1", n_hash, n_fin); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_full_block_same_cycle_done();
        run_msg(8'd0, 8'd32, 64'd64, 0, 0, 0);
        tests++; if (n_data != 64 || idx_err != 0 || n_pad != 0) begin fails++; $display("FAIL ll64_writes: got data=%0d bad=%0d pad=%0d want 64/0/0", n_data, idx_err, n_pad); end
        tests++; if (n_cmp != 1 || cmp_t_q[0] !== 64'd64 || cmp_last_q[0] !== 1'b1) begin fails++; $display("FAIL ll64_cmp: got n=%0d t=%0d last=%b want 1/64/1", n_cmp, cmp_t_q[0], cmp_last_q[0]); end
        tests++; if (n_hash != 32 || n_fin != 1 || fin_ok != 1) begin fails++; $display("FAIL ll64_out: got bytes=%0d fin=%0d want 32/1", n_hash, n_fin); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_multi_block();
        logic [63:0] exp_t[3] = '{64'd64, 64'd128, 64'd130};
        logic        exp_l[3] = '{1'b0, 1'b0, 1'b1};
        run_msg(8'd0, 8'd32, 64'd130, 4, 0, 0);
        tests++; if (n_data != 130 || idx_err != 0) begin fails++; $display("FAIL ll130_data: got n=%0d bad=%0d want 130/0", n_data, idx_err); end
        tests++; if (n_pad != 62 || pad_first != 2 || pad_err != 0) begin fails++; $display("FAIL ll130_pad: got n=%0d first=%0d err=%0d want 62/2/0", n_pad, pad_first, pad_err); end
        tests++; if (n_cmp != 3) begin fails++; $display("FAIL ll130_ncmp: got %0d want 3", n_cmp); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (cmp_t_q.size() <= i || cmp_t_q[i] !== exp_t[i] || cmp_last_q[i] !== exp_l[i]) begin
                fails++; $display("FAIL ll130_cmp%0d: got t=%0d last=%b want t=%0d last=%b", i, cmp_t_q[i], cmp_last_q[i], exp_t[i], exp_l[i]);
            end
        end
        tests++; if (n_hash != 32 || hash_err != 0 || n_fin != 1) begin fails++; $display("FAIL ll130_out: got bytes=%0d bad=%0d fin=%0d want 32/0/1", n_hash, hash_err, n_fin); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_keyed();
        run_msg(8'd16, 8'd16, 64'd0, 2, 0, 0);
        tests++; if (n_init != 1 || n_data != 64 || n_pad != 0) begin fails++; $display("FAIL keyed_writes: got init=%0d data=%0d pad=%0d want 1/64/0", n_init, n_data, n_pad); end
        tests++; if (n_cmp != 1 || cmp_t_q[0] !== 64'd64 || cmp_last_q[0] !== 1'b1) begin fails++; $display("FAIL keyed_cmp: got n=%0d t=%0d last=%b want 1/64/1", n_cmp, cmp_t_q[0], cmp_last_q[0]); end
        tests++; if (n_hash != 16 || hash_err != 0 || fin_ok != 1) begin fails++; $display("FAIL keyed_out: got bytes=%0d bad=%0d fin_on_last=%0d want 16/0/1", n_hash, hash_err, fin_ok); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_byte_in_comp();
        run_msg(8'd0, 8'd8, 64'd64, 6, 1, 0);
        tests++; if (inj_we != 0 || n_data != 64) begin fails++; $display("FAIL comp_byte_dropped: got we=%0d data=%0d want 0/64", inj_we, n_data); end
        tests++; if (n_cmp != 1 || cmp_t_q[0] !== 64'd64 || n_hash != 8) begin fails++; $display("FAIL comp_byte_flow: got cmp=%0d t=%0d bytes=%0d want 1/64/8", n_cmp, cmp_t_q[0], n_hash); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (err_o !== EXP_ERR) begin fails++; $display("FAIL comp_byte_err_held: got %b want %b", err_o, EXP_ERR); end
    endtask

    task automatic test_one_byte();
        run_msg(8'd0, 8'd1, 64'd1, 3, 0, 0);
        tests++; if (n_data != 1 || n_pad != 63 || pad_first != 1 || pad_err != 0) begin fails++; $display("FAIL ll1_writes: got data=%0d pad=%0d first=%0d want 1/63/1", n_data, n_pad, pad_first); end
        tests++; if (n_cmp != 1 || cmp_t_q[0] !== 64'd1 || cmp_last_q[0] !== 1'b1) begin fails++; $display("FAIL ll1_cmp: got n=%0d t=%0d last=%b want 1/1/1", n_cmp, cmp_t_q[0], cmp_last_q[0]); end
        tests++; if (n_hash != 1 || fin_ok != 1 || hash_err != 0) begin fails++; $display("FAIL ll1_out: got bytes=%0d fin_on_last=%0d want 1/1", n_hash, fin_ok); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL ll1_err_cleared: got %b want 0", err_o); end
    endtask

    task automatic test_reset_in_out();
        logic [95:0] outs;
        int late_v, late_fin;
        run_msg(8'd0, 8'd32, 64'd5, 2, 0, 1);
        tests++; if (n_hash != 1) begin fails++; $display("FAIL abort_reached_out: got bytes=%0d want 1", n_hash); end
        nreset = 0;
        #1;
        outs = {busy_o, buf_we_o, buf_idx_o, buf_zero_o, h_init_o, cmp_start_o, cmp_t_o,
                cmp_last_o, hash_rd_idx_o, hash_v_o, hash_o, hash_finished_o, err_o};
        tests++; if (outs !== '0) begin fails++; $display("FAIL abort_outputs: got %h want 0", outs); end
        repeat (2) @(posedge clk);
        #1;
        nreset = 1;
        late_v = 0; late_fin = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (hash_v_o) late_v++;
            if (hash_finished_o) late_fin++;
        end
        tests++; if (late_v != 0 || late_fin != 0 || busy_o !== 1'b0) begin fails++; $display("FAIL abort_no_resume: got v=%0d fin=%0d busy=%b want 0/0/0", late_v, late_fin, busy_o); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_short();
        test_full_block_same_cycle_done();
        test_multi_block();
        test_keyed();
        test_byte_in_comp();
        test_one_byte();
        test_reset_in_out();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
